div_hilo_ctrl: RTL and testbench
================================

DIV_HILO_CTRL -- requirements
Module: div_hilo_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  execute stage presents a DIV/DIVU instruction this cycle.
REQ-005 op_signed  in  1  1 = DIV (signed), 0 = DIVU.
REQ-006 rs_val, rt_val  in  32 each  dividend and divisor from register file.
REQ-007 mthi_we, mtlo_we  in  1 each  direct HI/LO write request; mt_data  in  32  write data.
REQ-008 div_start  out  1  one-cycle start pulse to the sequential divider.
REQ-009 div_dividend, div_divisor  out  32 each  operands held stable from div_start until result capture.
REQ-010 div_signed  out  1  divider mode select, held with the operands.
REQ-011 div_busy  in  1  divider busy flag; div_q, div_r  in  32 each  divider quotient and remainder.
REQ-012 stall  out  1  freeze the upstream pipeline.
REQ-013 done  out  1  one-cycle pulse when HI/LO are updated by a division.
REQ-014 hi, lo  out  32 each  architectural HI (remainder) and LO (quotient).

Function
REQ-015 States SHALL be IDLE, START, WAIT_BUSY, RUN, SETTLE; the state register and all outputs except stall SHALL be registered.
REQ-016 In IDLE with op_valid=1 and rt_val!=0: latch operands and op_signed; next state START.
REQ-017 In START: div_start=1 for exactly this cycle; next state WAIT_BUSY.
REQ-018 In WAIT_BUSY: stay until div_busy=1, then RUN.
REQ-019 In RUN: stay while div_busy=1; on div_busy=0, go to SETTLE.
REQ-020 In SETTLE: on the closing edge, load lo<=div_q and hi<=div_r; done=1 in the following cycle; next state IDLE.
REQ-021 stall SHALL be (state==IDLE && op_valid && rt_val!=0) || state!=IDLE (combinational).
REQ-022 Timing: with a divider that raises busy one edge after start and holds it 32 cycles, op accepted in cycle 0 gives div_start in cycle 1, HI/LO updated at end of cycle 35, done in cycle 36, stall high cycles 0-35.
REQ-023 Divisor zero (rt_val==0) in IDLE: no div_start, no stall, HI/LO unchanged, done stays 0.
REQ-024 mthi_we/mtlo_we SHALL update hi/lo on the next edge only in IDLE; they SHALL be ignored in any other state.
REQ-025 Simultaneous op_valid (nonzero divisor) and mt write in IDLE: division is accepted, mt write dropped.
REQ-026 Simultaneous mthi_we and mtlo_we: both registers written with mt_data.
REQ-027 op_valid outside IDLE SHALL be ignored (upstream is stalled).
REQ-028 Consecutive divisions: a new op_valid is accepted in the cycle done is high (state IDLE).

Reset
REQ-029 On reset: state=IDLE, hi=0, lo=0, div_start=0, done=0, div_dividend=0, div_divisor=0, div_signed=0; stall follows REQ-021.
REQ-030 Reset asserted mid-operation SHALL abandon the division with no HI/LO update; the divider shares the same reset.

Configuration
REQ-031 Macro DIV_ZERO_TRAP_EN: when defined, an output div_zero_exc (1 bit, registered, reset 0) SHALL pulse for one cycle after op_valid with rt_val==0 in IDLE.
REQ-032 Without DIV_ZERO_TRAP_EN the port SHALL not exist and zero-divisor handling is per REQ-023 only.

Verification
REQ-033 DIV rs=7, rt=2 -> lo=3, hi=1, done in cycle 36, stall cycles 0-35.
REQ-034 DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU rs=0xFFFFFFFF, rt=2 -> div_signed=0, lo=0x7FFFFFFF, hi=1.
REQ-036 hi/lo preset via mthi/mtlo to 0xA5A5A5A5; DIV rt=0 -> no div_start, stall=0, hi/lo unchanged; div_zero_exc pulse only with DIV_ZERO_TRAP_EN.
REQ-037 Reset asserted in cycle 20 of a division -> state IDLE, hi=lo=0, done never pulses; next DIV 9/3 -> lo=3, hi=0.
REQ-038 mtlo_we with data 0x1234 during RUN -> lo unchanged; same write in IDLE -> lo=0x1234 next cycle.

Source files
------------

// File: rtl/div_hilo_ctrl_if.sv
// Bus between the HI/LO divide controller and the sequential divider.
// The controller drives the launch side; the divider returns its busy flag and its result.
interface div_hilo_ctrl_if;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_signed;
    logic        div_busy;
    logic [31:0] div_q;
    logic [31:0] div_r;

    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        output div_signed,
        input  div_busy,
        input  div_q,
        input  div_r
    );

    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        input  div_signed,
        output div_busy,
        output div_q,
        output div_r
    );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequences one DIV/DIVU through an external divider and commits q/r into LO/HI; done pulses one cycle after commit.
// Upstream is held via combinational stall for the whole operation; DIV_ZERO_TRAP_EN adds a div_zero_exc pulse.
module div_hilo_ctrl (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_valid,
    input  logic               op_signed,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    input  logic               mthi_we,
    input  logic               mtlo_we,
    input  logic [31:0]        mt_data,
    div_hilo_ctrl_if.master    div,
    output logic               stall,
    output logic               done,
    output logic [31:0]        hi,
    output logic [31:0]        lo
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic               div_zero_exc
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        div_zero;
    logic        start_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic        signed_q;

    assign div_zero = (rt_val == 32'd0);
    assign accept   = (state == IDLE) && op_valid && !div_zero;
    assign stall    = accept || (state != IDLE);

    assign div.div_start    = start_q;
    assign div.div_dividend = dividend_q;
    assign div.div_divisor  = divisor_q;
    assign div.div_signed   = signed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (div.div_busy) state_nxt = RUN;
            RUN:       if (!div.div_busy) state_nxt = SETTLE;
            SETTLE:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Operands stay frozen from launch until the next accepted op so the divider may sample them at any time.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_q    <= 1'b0;
            done       <= 1'b0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            signed_q   <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            start_q <= accept;
            done    <= (state == SETTLE);
            if (accept) begin
                dividend_q <= rs_val;
                divisor_q  <= rt_val;
                signed_q   <= op_signed;
            end
            if (state == SETTLE) begin
                lo <= div.div_q;
                hi <= div.div_r;
            end else if ((state == IDLE) && !accept) begin
                // A move-to write loses to a division accepted in the same cycle.
                if (mthi_we) hi <= mt_data;
                if (mtlo_we) lo <= mt_data;
            end
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            div_zero_exc <= 1'b0;
        end else begin
            div_zero_exc <= (state == IDLE) && op_valid && div_zero;
        end
    end
`endif

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a 32-cycle divider model and a HI/LO scoreboard checked on done.
module tb_div_hilo_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] mt_data;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef DIV_ZERO_TRAP_EN
    logic        div_zero_exc;
`endif

    div_hilo_ctrl_if dif ();

    div_hilo_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_signed    (op_signed),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .mthi_we      (mthi_we),
        .mtlo_we      (mtlo_we),
        .mt_data      (mt_data),
        .div          (dif.master),
        .stall        (stall),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
`ifdef DIV_ZERO_TRAP_EN
        ,
        .div_zero_exc (div_zero_exc)
`endif
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;
    int unsigned busy_cnt;

    // Divider: busy rises one edge after start and stays high for 32 cycles.
    always @(posedge clock) begin
        if (reset) begin
            dif.div_busy <= 1'b0;
            dif.div_q    <= 32'd0;
            dif.div_r    <= 32'd0;
            busy_cnt     <= 0;
        end else if (dif.div_start) begin
            dif.div_busy <= 1'b1;
            busy_cnt     <= 31;
            if (dif.div_signed) begin
                dif.div_q <= $signed(dif.div_dividend) / $signed(dif.div_divisor);
                dif.div_r <= $signed(dif.div_dividend) % $signed(dif.div_divisor);
            end else begin
                dif.div_q <= dif.div_dividend / dif.div_divisor;
                dif.div_r <= dif.div_dividend % dif.div_divisor;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            dif.div_busy <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!reset && done) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, required no done pulse", hi, lo);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({hi, lo} !== mon_exp) begin
                    fails++;
                    $display("FAIL hilo_result: got hi=%h lo=%h, required hi=%h lo=%h",
                             hi, lo, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller is just past the edge that opens cycle 0; returns after sampling cycle 35.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input bit inject, input bit mt_also, input bit chained);
        bit          win_ok;
        logic [31:0] lo_keep;
        logic [31:0] hi_keep;
        hi_keep   = hi;
        lo_keep   = lo;
        op_valid  = 1'b1;
        op_signed = sgn;
        rs_val    = a;
        rt_val    = b;
        if (mt_also) begin
            mthi_we = 1'b1;
            mt_data = 32'hDEADBEEF;
        end
        sb_q.push_back({exp_hi, exp_lo});
        @(negedge clock);
        chk("stall_c0", {31'd0, stall}, 32'd1);
        if (chained) chk("done_at_accept", {31'd0, done}, 32'd1);
        tick();
        op_valid = 1'b0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        @(negedge clock);
        chk("div_start_c1", {31'd0, dif.div_start}, 32'd1);
        chk("div_dividend", dif.div_dividend, a);
        chk("div_divisor", dif.div_divisor, b);
        chk("div_signed", {31'd0, dif.div_signed}, {31'd0, sgn});
        if (mt_also) chk("mthi_dropped", hi, hi_keep);
        win_ok = 1'b1;
        for (int c = 2; c <= 35; c++) begin
            tick();
            if (inject && c == 10) begin
                lo_keep  = lo;
                mtlo_we  = 1'b1;
                mt_data  = 32'h00001234;
                op_valid = 1'b1;
                rs_val   = 32'd1;
                rt_val   = 32'd1;
            end else begin
                mtlo_we  = 1'b0;
                op_valid = 1'b0;
            end
            @(negedge clock);
            if (!stall || dif.div_start || done) win_ok = 1'b0;
            if (inject && c == 11) chk("mtlo_in_run", lo, lo_keep);
        end
        chk("stall_window", {31'd0, win_ok}, 32'd1);
    endtask

    task automatic finish_div();
        @(negedge clock);
        chk("done_c36", {31'd0, done}, 32'd1);
        chk("stall_c36", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        bit saw_done;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_signed = 1'b0;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        mt_data   = 32'd0;
        tick();
        tick();
        @(negedge clock);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_start", {31'd0, dif.div_start}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_operands", dif.div_dividend | dif.div_divisor | {31'd0, dif.div_signed}, 32'd0);
        reset = 1'b0;

        tick(); run_div(1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 0, 0, 0);
        tick(); finish_div();
        tick(); run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0);
        tick(); finish_div();
        tick(); run_div(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 0, 0, 0);
        tick(); finish_div();

        tick();
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hA5A5A5A5;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        @(negedge clock);
        chk("mthi_preset", hi, 32'hA5A5A5A5);
        chk("mtlo_preset", lo, 32'hA5A5A5A5);

        tick();
        op_valid = 1'b1; op_signed = 1'b1; rs_val = 32'd5; rt_val = 32'd0;
        @(negedge clock);
        chk("zero_stall_c0", {31'd0, stall}, 32'd0);
        tick();
        op_valid = 1'b0;
        @(negedge clock);
        chk("zero_no_start", {31'd0, dif.div_start}, 32'd0);
        chk("zero_stall_c1", {31'd0, stall}, 32'd0);
        chk("zero_hi", hi, 32'hA5A5A5A5);
        chk("zero_lo", lo, 32'hA5A5A5A5);
`ifdef DIV_ZERO_TRAP_EN
        chk("zero_exc_pulse", {31'd0, div_zero_exc}, 32'd1);
`endif
        tick();
        @(negedge clock);
        chk("zero_no_start_c2", {31'd0, dif.div_start}, 32'd0);
`ifdef DIV_ZERO_TRAP_EN
        chk("zero_exc_clear", {31'd0, div_zero_exc}, 32'd0);
`endif

        tick(); run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1, 0, 0);
        tick(); run_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 0, 1, 1);
        tick(); finish_div();

        tick();
        mtlo_we = 1'b1; mt_data = 32'h00001234;
        tick();
        mtlo_we = 1'b0;
        @(negedge clock);
        chk("mtlo_idle", lo, 32'h00001234);
        chk("mtlo_hi_kept", hi, 32'd2);

        tick();
        op_valid = 1'b1; op_signed = 1'b1; rs_val = 32'd50; rt_val = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            tick();
            op_valid = 1'b0;
            if (c == 20) reset = 1'b1;
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_start", {31'd0, dif.div_start}, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);

        tick(); run_div(1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0, 0);
        tick(); finish_div();

        tick();
        tick();
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
